// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry of the 16x16 register file and
// the write-back entry layout carried through the write-back queue.
package regfile_pkg;

  localparam int REG_W  = 16;
  localparam int REG_AW = 4;

  // One pending register write: destination index and value.
  typedef struct packed {
    logic [REG_AW-1:0] reg_addr;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

  // R0 is hard-wired; writes to it are accepted and discarded.
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Write-back request channel between the pipeline write-back stage (master)
// and the write-back queue (slave). Valid/ready handshake.
interface regfile_wb_queue_if #(
  parameter int AW    = 4,
  parameter int WIDTH = 16
) ();

  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_reg;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_reg,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_reg,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/regfile_wb_queue_dec.sv
// Register-select decoder: turns a register index into a one-hot write-enable
// vector, all zero when the enable input is low.
module reg_onehot_dec #(
  parameter int AW = 4
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [(1<<AW)-1:0] onehot
);

  // Single set bit at addr when enabled, otherwise no register is written.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue owning the write side of the register file. Buffers
// write-back requests in a small FIFO, drains the head into the per-register
// write enables one entry per cycle, and forwards the youngest in-flight value
// to both read ports. Widths default to the shared register-file geometry;
// WIDTH/AW are expected to match REG_W/REG_AW since entries use wb_entry_t.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REG_W,
  parameter int AW    = REG_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_queue_if.slave        wb,
  input  logic                     drain_en,
  output logic [(1<<AW)-1:0]       rf_write_en,
  output logic [WIDTH-1:0]         rf_d,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [WIDTH-1:0]         byp_data1,
  output logic [WIDTH-1:0]         byp_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  wb_entry_t     head;
  logic          push_hs;
  logic          push;
  logic          pop;

  // Pointers carry a wrap bit: equal means empty, equal except MSB means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign count = count_q;

  // Ready depends only on fullness: a pop in the same cycle does not free a slot.
  assign wb.wb_ready = !full;
  assign push_hs     = wb.wb_valid && wb.wb_ready;
  // R0 writes finish the handshake but never occupy a slot.
  assign push        = push_hs && (wb.wb_reg != REG_ZERO);
  assign pop         = !empty && drain_en;

  assign head = mem_q[rd_ptr_q[IW-1:0]];
  assign rf_d = empty ? '0 : head.data;

  reg_onehot_dec #(
    .AW (AW)
  ) u_dec (
    .en     (pop),
    .addr   (head.reg_addr),
    .onehot (rf_write_en)
  );

  // Next-state for pointers and occupancy from the push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage next-state: write the incoming request at the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[IW-1:0]] = '{reg_addr: wb.wb_reg, data: wb.wb_data};
    end
  end

  // Control state, cleared asynchronously so queued writes vanish at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payloads carry no reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Bypass scan oldest to youngest so the last (youngest) match wins;
  // the head draining this cycle is still a valid entry.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i) < count_q) begin
        if ((rd_addr1 != REG_ZERO) &&
            (mem_q[IW'(rd_ptr_q[IW-1:0] + IW'(i))].reg_addr == rd_addr1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = mem_q[IW'(rd_ptr_q[IW-1:0] + IW'(i))].data;
        end
        if ((rd_addr2 != REG_ZERO) &&
            (mem_q[IW'(rd_ptr_q[IW-1:0] + IW'(i))].reg_addr == rd_addr2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = mem_q[IW'(rd_ptr_q[IW-1:0] + IW'(i))].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for the register-file write-back queue.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        drain_en;
  logic [15:0] rf_write_en;
  logic [15:0] rf_d;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [15:0] byp_data1;
  logic [15:0] byp_data2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int vectors     = 0;
  int miscompares = 0;

  regfile_wb_queue_if #(.AW(AW), .WIDTH(WIDTH)) wbif ();

  regfile_wb_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wbif),
    .drain_en    (drain_en),
    .rf_write_en (rf_write_en),
    .rf_d        (rf_d),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic idle_inputs();
    wbif.wb_valid = 1'b0;
    wbif.wb_reg   = '0;
    wbif.wb_data  = '0;
    drain_en      = 1'b0;
    rd_addr1      = '0;
    rd_addr2      = '0;
  endtask

  // Present one request for exactly one clock edge; returns 2 time units after it.
  task automatic do_push(input logic [3:0] r, input logic [15:0] d);
    wbif.wb_valid = 1'b1;
    wbif.wb_reg   = r;
    wbif.wb_data  = d;
    @(posedge clk); #1;
    wbif.wb_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    rd_addr1 = 4'd3;
    rd_addr2 = 4'd5;
    #1;
    vectors++; if (wbif.wb_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", wbif.wb_ready); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b expected 0", full); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count); end
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL rst_en: got %h expected 0000", rf_write_en); end
    vectors++; if (rf_d !== 16'h0000) begin miscompares++; $display("FAIL rst_rfd: got %h expected 0000", rf_d); end
    vectors++; if ({byp_hit1, byp_hit2} !== 2'b00) begin miscompares++; $display("FAIL rst_hit: got %b expected 00", {byp_hit1, byp_hit2}); end
    vectors++; if ({byp_data1, byp_data2} !== 32'h0) begin miscompares++; $display("FAIL rst_bdata: got %h expected 0", {byp_data1, byp_data2}); end
    rd_addr1 = '0;
    rd_addr2 = '0;
  endtask

  task automatic test_latency();
    drain_en = 1'b1;
    do_push(4'd3, 16'hBEEF);
    vectors++; if (rf_write_en !== 16'h0008) begin miscompares++; $display("FAIL lat_en: got %h expected 0008", rf_write_en); end
    vectors++; if (rf_d !== 16'hBEEF) begin miscompares++; $display("FAIL lat_rfd: got %h expected beef", rf_d); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL lat_count: got %0d expected 1", count); end
    @(posedge clk); #2;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL lat_empty: got %b expected 1", empty); end
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL lat_idle_en: got %h expected 0000", rf_write_en); end
    vectors++; if (rf_d !== 16'h0000) begin miscompares++; $display("FAIL lat_idle_rfd: got %h expected 0000", rf_d); end
    drain_en = 1'b0;
  endtask

  task automatic test_full();
    logic [15:0] exp_en [4];
    logic [15:0] exp_d  [4];
    exp_en = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
    exp_d  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    drain_en = 1'b0;
    do_push(4'd1, 16'h1111);
    do_push(4'd2, 16'h2222);
    do_push(4'd3, 16'h3333);
    do_push(4'd4, 16'h4444);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b expected 1", full); end
    vectors++; if (wbif.wb_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b expected 0", wbif.wb_ready); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", count); end
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL full_hold_en: got %h expected 0000", rf_write_en); end
    vectors++; if (rf_d !== 16'h1111) begin miscompares++; $display("FAIL full_hold_rfd: got %h expected 1111", rf_d); end
    do_push(4'd5, 16'h5555);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_refuse: got %0d expected 4", count); end
    drain_en = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (rf_write_en !== exp_en[k]) begin miscompares++; $display("FAIL full_drain_en[%0d]: got %h expected %h", k, rf_write_en, exp_en[k]); end
      vectors++; if (rf_d !== exp_d[k]) begin miscompares++; $display("FAIL full_drain_rfd[%0d]: got %h expected %h", k, rf_d, exp_d[k]); end
      @(posedge clk); #2;
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL full_drained_empty: got %b expected 1", empty); end
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL full_drained_en: got %h expected 0000", rf_write_en); end
    drain_en = 1'b0;
  endtask

  task automatic test_bypass();
    drain_en = 1'b0;
    rd_addr1 = 4'd5;
    rd_addr2 = 4'd7;
    do_push(4'd5, 16'hAAAA);
    vectors++; if ({byp_hit1, byp_data1} !== {1'b1, 16'hAAAA}) begin miscompares++; $display("FAIL byp_one: got %b/%h expected 1/aaaa", byp_hit1, byp_data1); end
    do_push(4'd5, 16'h5555);
    vectors++; if ({byp_hit1, byp_data1} !== {1'b1, 16'h5555}) begin miscompares++; $display("FAIL byp_young: got %b/%h expected 1/5555", byp_hit1, byp_data1); end
    vectors++; if ({byp_hit2, byp_data2} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL byp_miss: got %b/%h expected 0/0000", byp_hit2, byp_data2); end
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL byp_count: got %0d expected 2", count); end
    drain_en = 1'b1;
    #1;
    vectors++; if ({rf_write_en, rf_d} !== {16'h0020, 16'hAAAA}) begin miscompares++; $display("FAIL byp_drain_old: got %h/%h expected 0020/aaaa", rf_write_en, rf_d); end
    vectors++; if ({byp_hit1, byp_data1} !== {1'b1, 16'h5555}) begin miscompares++; $display("FAIL byp_during1: got %b/%h expected 1/5555", byp_hit1, byp_data1); end
    @(posedge clk); #2;
    vectors++; if ({rf_write_en, rf_d} !== {16'h0020, 16'h5555}) begin miscompares++; $display("FAIL byp_drain_new: got %h/%h expected 0020/5555", rf_write_en, rf_d); end
    vectors++; if ({byp_hit1, byp_data1} !== {1'b1, 16'h5555}) begin miscompares++; $display("FAIL byp_during2: got %b/%h expected 1/5555", byp_hit1, byp_data1); end
    @(posedge clk); #2;
    vectors++; if ({byp_hit1, byp_data1} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL byp_after: got %b/%h expected 0/0000", byp_hit1, byp_data1); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL byp_empty: got %b expected 1", empty); end
    drain_en = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
  endtask

  task automatic test_r0();
    drain_en      = 1'b1;
    rd_addr2      = 4'd0;
    wbif.wb_valid = 1'b1;
    wbif.wb_reg   = 4'd0;
    wbif.wb_data  = 16'h1234;
    #1;
    vectors++; if (wbif.wb_ready !== 1'b1) begin miscompares++; $display("FAIL r0_ready: got %b expected 1", wbif.wb_ready); end
    @(posedge clk); #1;
    wbif.wb_valid = 1'b0;
    #1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL r0_count: got %0d expected 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL r0_empty: got %b expected 1", empty); end
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL r0_en: got %h expected 0000", rf_write_en); end
    vectors++; if ({byp_hit2, byp_data2} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL r0_byp: got %b/%h expected 0/0000", byp_hit2, byp_data2); end
    drain_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sr [12];
    logic [15:0] sd [12];
    logic [15:0] exp_en;
    sr = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1, 4'd2};
    for (int k = 0; k < 12; k++) sd[k] = 16'h6001 + 16'(k);
    drain_en = 1'b0;
    do_push(sr[0], sd[0]);
    do_push(sr[1], sd[1]);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_prefill: got %0d expected 2", count); end
    for (int k = 0; k < 10; k++) begin
      wbif.wb_valid = 1'b1;
      wbif.wb_reg   = sr[k+2];
      wbif.wb_data  = sd[k+2];
      drain_en      = 1'b1;
      #1;
      exp_en = 16'h0001 << sr[k];
      vectors++; if ({rf_write_en, rf_d} !== {exp_en, sd[k]}) begin miscompares++; $display("FAIL b2b_order[%0d]: got %h/%h expected %h/%h", k, rf_write_en, rf_d, exp_en, sd[k]); end
      @(posedge clk); #1;
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d expected 2", k, count); end
    end
    wbif.wb_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      #1;
      exp_en = 16'h0001 << sr[k];
      vectors++; if ({rf_write_en, rf_d} !== {exp_en, sd[k]}) begin miscompares++; $display("FAIL b2b_tail[%0d]: got %h/%h expected %h/%h", k, rf_write_en, rf_d, exp_en, sd[k]); end
      @(posedge clk); #1;
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    drain_en = 1'b0;
  endtask

  task automatic test_async_reset();
    drain_en = 1'b0;
    rd_addr1 = 4'd9;
    do_push(4'd9,  16'h9999);
    do_push(4'd10, 16'hAAAA);
    do_push(4'd11, 16'hBBBB);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
    drain_en = 1'b1;
    #1;
    vectors++; if (rf_write_en !== 16'h0200) begin miscompares++; $display("FAIL arst_pre_en: got %h expected 0200", rf_write_en); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (rf_write_en !== 16'h0000) begin miscompares++; $display("FAIL arst_en: got %h expected 0000", rf_write_en); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL arst_count: got %0d expected 0", count); end
    vectors++; if ({empty, byp_hit1, rf_d} !== {1'b1, 1'b0, 16'h0000}) begin miscompares++; $display("FAIL arst_state: got %b/%b/%h expected 1/0/0000", empty, byp_hit1, rf_d); end
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      vectors++; if ({rf_write_en, empty, count} !== {16'h0000, 1'b1, 3'd0}) begin miscompares++; $display("FAIL arst_stale[%0d]: got %h/%b/%0d expected 0000/1/0", c, rf_write_en, empty, count); end
    end
    drain_en = 1'b0;
    rd_addr1 = '0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_latency();
    test_full();
    test_bypass();
    test_r0();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
